// File: rtl/inst_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetcher_pkg
// Shared constants and types for the fetch stage:
//   - DATA_W / data_bus_t   : machine word width and type
//   - IQ_DEPTH_LOG_DEF      : default log2 depth of the instruction queue
//   - OPC_JAL               : RV32 JAL major opcode
//   - fetch_state_e         : fetch FSM state encodings
//   - iq_entry_t            : one instruction queue entry {inst, pc, pred_pc}
//   - jal_imm()             : J-type immediate decode, present only when
//                             FETCH_JAL_PREDICT_EN is defined
// -----------------------------------------------------------------------------
package inst_fetcher_pkg;

  localparam int DATA_W           = 32;
  localparam int IQ_DEPTH_LOG_DEF = 4;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef logic [DATA_W-1:0] data_bus_t;

  typedef enum logic {
    S_REQ  = 1'b0,  // decide whether to issue a read this cycle
    S_WAIT = 1'b1   // one read outstanding, waiting for ic_ready
  } fetch_state_e;

  typedef struct packed {
    data_bus_t inst;
    data_bus_t pc;
    data_bus_t pred_pc;
  } iq_entry_t;

`ifdef FETCH_JAL_PREDICT_EN
  // Sign-extended JAL offset: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  function automatic data_bus_t jal_imm(input data_bus_t inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction
`endif

endpackage

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// In-order synchronous FIFO of fetched instructions. The head entry is
// presented combinationally; pointers wrap modulo 2**DEPTH_LOG and count is
// DEPTH_LOG+1 bits so "full" is simply its MSB.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail (ignored if full and not deq)
//   push_data  : entry to append
//   deq        : consumer takes the head entry (ignored when empty)
//   flush      : empty the queue; overrides same-cycle push and deq
//   count      : number of valid entries
//   valid      : queue non-empty
//   head       : entry at the head
// Parameters:
//   DEPTH_LOG  : log2 of the number of entries
// -----------------------------------------------------------------------------
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH_LOG = IQ_DEPTH_LOG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  iq_entry_t            push_data,
  input  logic                 deq,
  input  logic                 flush,
  output logic [DEPTH_LOG:0]   count,
  output logic                 valid,
  output iq_entry_t            head
);

  localparam int                   DEPTH   = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = (DEPTH_LOG)'(1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE = (DEPTH_LOG+1)'(1);

  iq_entry_t            mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_deq;

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_deq  = deq && valid && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!count[DEPTH_LOG] || do_deq);

  // NOTE: sequential state is assigned with <= only, so every always_ff reads
  // the pre-edge values of its neighbours regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_deq)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, because valid is derived from the reset counter.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetcher.sv
// -----------------------------------------------------------------------------
// inst_fetcher
// Fetch stage between the ICache and decode/dispatch. Holds the fetch PC,
// issues single-cycle read pulses (at most one outstanding), and queues each
// returned word with its PC and predicted next PC. A redirect from commit
// flushes the queue and discards any response still in flight.
//
// Build option: FETCH_JAL_PREDICT_EN -- when defined, a fetched JAL predicts
// its own target (pc + J-immediate) and fetch follows it; otherwise the
// prediction is always pc+4 and JAL is resolved downstream via jump_en.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset (wins over rdy)
//   rdy         : global ready; low freezes all state and forces ic_rn low
//   ic_rn       : ICache read pulse, high only in S_REQ with queue space
//   ic_addr     : word-aligned fetch address
//   ic_ready    : ICache response valid (from the cycle after ic_rn)
//   ic_inst     : ICache instruction word
//   jump_en     : redirect from commit
//   jump_pc     : redirect target
//   iq_deq      : consumer takes the head entry
//   iq_valid    : head entry valid
//   iq_inst     : head instruction
//   iq_pc       : head instruction PC
//   iq_pred_pc  : head predicted next PC
// Parameters:
//   IQ_DEPTH_LOG : log2 of queue depth
//   RESET_PC     : fetch PC after reset
//
// ic_rn is decoded from the registered state so that a request leaves in the
// same cycle the FSM returns to S_REQ, giving one instruction per two cycles
// on back-to-back hits.
// -----------------------------------------------------------------------------
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int        IQ_DEPTH_LOG = IQ_DEPTH_LOG_DEF,
  parameter data_bus_t RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_rn,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_inst,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  input  logic        iq_deq,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_pred_pc
);

  fetch_state_e          state;
  data_bus_t             pc;
  data_bus_t             pred_pc;
  logic                  discard;
  logic [IQ_DEPTH_LOG:0] iq_count;
  logic                  iq_full;
  logic                  iq_push;
  iq_entry_t             iq_head;

  assign iq_full = iq_count[IQ_DEPTH_LOG];
  assign ic_addr = {pc[31:2], 2'b00};
  assign ic_rn   = !rst && rdy && (state == S_REQ) && !iq_full && !jump_en;

  // A returning word is kept only if it belongs to the current PC stream.
  assign iq_push = !rst && rdy && (state == S_WAIT) && ic_ready && !discard && !jump_en;

  // NOTE: every always_comb output gets a default before any conditional
  // override, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pred_pc = pc + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
    if (ic_inst[6:0] == OPC_JAL) pred_pc = pc + jal_imm(ic_inst);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else if (rdy) begin
      unique case (state)
        S_REQ: begin
          if (jump_en)       pc    <= jump_pc;
          else if (!iq_full) state <= S_WAIT;
        end
        S_WAIT: begin
          if (ic_ready) begin
            state   <= S_REQ;
            discard <= 1'b0;
            if (jump_en)       pc <= jump_pc;
            else if (!discard) pc <= pred_pc;
          end else if (jump_en) begin
            // The in-flight response belongs to the old stream; drop it on
            // arrival and only then fetch the redirect target.
            discard <= 1'b1;
            pc      <= jump_pc;
          end
        end
      endcase
    end
  end

  inst_queue #(
    .DEPTH_LOG (IQ_DEPTH_LOG)
  ) u_iq (
    .clk       (clk),
    .rst       (rst),
    .push      (iq_push),
    .push_data ('{inst: ic_inst, pc: pc, pred_pc: pred_pc}),
    .deq       (rdy && iq_deq),
    .flush     (rdy && jump_en),
    .count     (iq_count),
    .valid     (iq_valid),
    .head      (iq_head)
  );

  assign iq_inst    = iq_head.inst;
  assign iq_pc      = iq_head.pc;
  assign iq_pred_pc = iq_head.pred_pc;

endmodule
